// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock qualification and core reset release sequencer.
// Define PLL_RESET_SEQ_WATCHDOG_EN to retry the PLL when WAIT_LOCK exceeds LOCK_TIMEOUT cycles.
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [7:0] unlock_cnt,
  output logic [7:0] retry_cnt
);
  typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  localparam logic [16:0] RST_LAST = 17'(PLL_RST_CYCLES - 1);
  // The lock_s sample that leaves WAIT_LOCK already counts as the first stable cycle.
  localparam logic [16:0] STABLE_LAST = (STABLE_CYCLES > 1) ? 17'(STABLE_CYCLES - 2) : 17'd0;
  localparam logic [16:0] HOLD_LAST = 17'(HOLD_CYCLES - 1);
  if (PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > 255 || STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 || LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 131071) begin : g_bad_cfg
    $error("pll_reset_seq: parameter out of range");
  end
  state_t state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic sync_q, lock_s_q;
  logic pll_rst_q, pll_rst_d, core_rst_q, core_rst_d, ready_q, ready_d;
  logic [7:0] unlock_q, unlock_d;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  localparam logic [16:0] TIMEOUT_LAST = 17'(LOCK_TIMEOUT - 1);
  logic [7:0] retry_q, retry_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 17'd1;
    unlock_d = unlock_q;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    retry_d = retry_q;
`endif
    case (state_q)
      PLL_RESET: if (cnt_q == RST_LAST) begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end
      WAIT_LOCK: begin
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        if (lock_s_q) begin
          state_d = STABLE;
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RESET;
          cnt_d = '0;
          retry_d = (retry_q != 8'hff) ? retry_q + 8'd1 : retry_q;
        end
`else
        cnt_d = '0;
        state_d = lock_s_q ? STABLE : WAIT_LOCK;
`endif
      end
      STABLE: if (!lock_s_q) begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
        state_d = HOLD;
        cnt_d = '0;
      end
      HOLD: if (!lock_s_q) begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end else if (cnt_q == HOLD_LAST) begin
        state_d = RUN;
        cnt_d = '0;
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          unlock_d = (unlock_q != 8'hff) ? unlock_q + 8'd1 : unlock_q;
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d = '0;
      end
    endcase
    pll_rst_d = state_d == PLL_RESET;
    core_rst_d = state_d != RUN;
    ready_d = state_d == RUN;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= PLL_RESET;
      cnt_q <= '0;
      sync_q <= 1'b0;
      lock_s_q <= 1'b0;
      pll_rst_q <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q <= 1'b0;
      unlock_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= locked;
      lock_s_q <= sync_q;
      pll_rst_q <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q <= ready_d;
      unlock_q <= unlock_d;
    end
  end
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  always_ff @(posedge refclk) begin
    if (rst) retry_q <= '0;
    else retry_q <= retry_d;
  end
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif
  assign pll_rst = pll_rst_q;
  assign core_rst = core_rst_q;
  assign ready = ready_q;
  assign unlock_cnt = unlock_q;
endmodule
